// File: rtl/gather_turn_sched.sv
// Kernel-turn sequencer: LOAD -> ACCUM -> SETTLE(2) -> DRAIN(4 words) per turn; start->kernel_req 2 cycles, last beat->rd_req >=3.
// Waits indefinitely on kernel_ack, in_valid and rd_ready; GATHER_PERF_EN adds the perf_stall_cnt output.
module gather_turn_sched #(
  parameter int NO_OF_KERNEL = 16,
  parameter int CH_WIDTH     = 7,
  parameter int TURN_WIDTH   = ($clog2(NO_OF_KERNEL/4) < 1) ? 1 : $clog2(NO_OF_KERNEL/4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   cfg_channel_per_kernel,
  output logic                  kernel_req,
  input  logic                  kernel_ack,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  valid_coming,
  output logic [CH_WIDTH-1:0]   cur_channel,
  output logic                  last_channel,
  output logic                  rd_req,
  input  logic                  rd_ready,
  output logic [TURN_WIDTH-1:0] turn_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
`ifdef GATHER_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [TURN_WIDTH-1:0] LAST_TURN = TURN_WIDTH'(NO_OF_KERNEL/4 - 1);
  localparam logic [TURN_WIDTH-1:0] TURN_ONE  = 1;
  localparam logic [CH_WIDTH:0]     CH_ONE    = 1;

  logic [2:0]          state;
  logic [CH_WIDTH-1:0] cfg_q;
  // One extra bit so a full 2^CH_WIDTH-1 channel turn never wraps the compare.
  logic [CH_WIDTH:0]   ch_cnt;
  logic [CH_WIDTH:0]   ch_nxt;
  logic [1:0]          wd_cnt;
  logic                settle_cnt;
  logic                beat;
  logic                at_last;
  logic                start_ok;

  assign in_ready     = (state == S_ACCUM);
  assign beat         = in_valid & in_ready;
  assign ch_nxt       = ch_cnt + CH_ONE;
  assign at_last      = (ch_nxt == {1'b0, cfg_q});
  assign valid_coming = beat;
  assign cur_channel  = beat ? ch_nxt[CH_WIDTH-1:0] : '0;
  assign last_channel = beat & at_last;
  assign rd_req       = (state == S_DRAIN) & rd_ready;
  assign start_ok     = (state == S_IDLE) & start & (cfg_channel_per_kernel != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_q      <= '0;
      ch_cnt     <= '0;
      wd_cnt     <= '0;
      settle_cnt <= 1'b0;
      kernel_req <= 1'b0;
      turn_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cfg_q    <= cfg_channel_per_kernel;
            turn_idx <= '0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        S_LOAD: begin
          // Request goes out one cycle after entry; an ack is only honoured while it is up.
          if (kernel_req && kernel_ack) begin
            kernel_req <= 1'b0;
            ch_cnt     <= '0;
            state      <= S_ACCUM;
          end else begin
            kernel_req <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            ch_cnt <= ch_nxt;
            if (at_last) begin
              settle_cnt <= 1'b0;
              state      <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          settle_cnt <= ~settle_cnt;
          if (settle_cnt) begin
            wd_cnt <= '0;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_ready) begin
            wd_cnt <= wd_cnt + 2'd1;
            if (wd_cnt == 2'd3) begin
              if (turn_idx == LAST_TURN) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                turn_idx <= turn_idx + TURN_ONE;
                state    <= S_LOAD;
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATHER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (start_ok) begin
      perf_stall_cnt <= '0;
    end else if (((state == S_ACCUM) && !in_valid) || ((state == S_DRAIN) && !rd_ready)) begin
      if (perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gather_turn_sched.sv
// Bench for gather_turn_sched: random handshakes, scoreboard of beat/read events, phase-level reference model.
module tb_gather_turn_sched;
  localparam int NK    = 16;
  localparam int CHW   = 7;
  localparam int TW    = 2;
  localparam int TURNS = NK / 4;

  localparam int P_IDLE = 0, P_LOAD = 1, P_ACCUM = 2, P_SETTLE = 3, P_DRAIN = 4, P_DONE = 5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [CHW-1:0] cfg;
  logic kernel_req, kernel_ack, in_valid, in_ready, valid_coming;
  logic [CHW-1:0] cur_channel;
  logic last_channel, rd_req, rd_ready;
  logic [TW-1:0] turn_idx;
  logic busy, done, cfg_err;
`ifdef GATHER_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  gather_turn_sched #(.NO_OF_KERNEL(NK), .CH_WIDTH(CHW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_channel_per_kernel(cfg),
    .kernel_req(kernel_req), .kernel_ack(kernel_ack),
    .in_valid(in_valid), .in_ready(in_ready),
    .valid_coming(valid_coming), .cur_channel(cur_channel), .last_channel(last_channel),
    .rd_req(rd_req), .rd_ready(rd_ready), .turn_idx(turn_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef GATHER_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int ch;
    bit last;
    int turn;
    bit rd;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int n_beats, n_last, n_reads, n_done;
  bit gaps, rand_ack, stray, chaos;

  // reference model state (phase of the current cycle)
  int phase = P_IDLE;
  int cfg_m, load_cnt, beats_m, settle_m, words_m, turn_m;
  bit err_m;
  int perf_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got nothing expected an event at %0t", nm, $time);
  endtask

  // handshake drivers
  initial begin
    kernel_ack = 1'b0;
    in_valid = 1'b0;
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (kernel_req && !kernel_ack && (!rand_ack || $urandom_range(0, 2) == 0)) kernel_ack = 1'b1;
      else if (!kernel_req && stray && $urandom_range(0, 3) == 0) kernel_ack = 1'b1;
      else kernel_ack = 1'b0;
    end
  end

  // monitor + reference model
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_kernel_req", kernel_req, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid_coming", valid_coming, 0);
        chk("rst_cur_channel", cur_channel, 0);
        chk("rst_last_channel", last_channel, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_turn_idx", turn_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
`ifdef GATHER_PERF_EN
        chk("rst_perf", perf_stall_cnt, 0);
`endif
        phase = P_IDLE;
        err_m = 1'b0;
        perf_m = 0;
        exp_q.delete();
        continue;
      end
      chk("busy", busy, phase != P_IDLE);
      chk("done", done, phase == P_DONE);
      chk("in_ready", in_ready, phase == P_ACCUM);
      chk("cfg_err", cfg_err, err_m);
      chk("kernel_req", kernel_req, phase == P_LOAD && load_cnt > 0);
      chk("valid_coming", valid_coming, phase == P_ACCUM && in_valid);
      chk("rd_req", rd_req, phase == P_DRAIN && rd_ready);
      if (done) n_done++;
      if (valid_coming) begin
        n_beats++;
        if (last_channel) n_last++;
        if (exp_q.size() == 0) miss("beat_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("beat_kind", 32'(e.rd), 0);
          chk("cur_channel", cur_channel, e.ch);
          chk("last_channel", last_channel, e.last);
          chk("beat_turn", turn_idx, e.turn);
        end
      end
      if (rd_req) begin
        n_reads++;
        if (exp_q.size() == 0) miss("read_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("read_kind", 32'(e.rd), 1);
          chk("read_turn", turn_idx, e.turn);
        end
      end
      case (phase)
        P_IDLE: if (start) begin
          if (cfg == 0) err_m = 1'b1;
          else begin
            phase = P_LOAD; cfg_m = cfg; load_cnt = 0; turn_m = 0; perf_m = 0;
          end
        end
        P_LOAD: begin
          if (load_cnt > 0 && kernel_ack) begin phase = P_ACCUM; beats_m = 0; end
          else load_cnt++;
        end
        P_ACCUM: begin
          if (in_valid) begin
            beats_m++;
            if (beats_m == cfg_m) begin phase = P_SETTLE; settle_m = 0; end
          end else perf_m++;
        end
        P_SETTLE: begin
          settle_m++;
          if (settle_m == 2) begin phase = P_DRAIN; words_m = 0; end
        end
        P_DRAIN: begin
          if (rd_ready) begin
            words_m++;
            if (words_m == 4) begin
              if (turn_m == TURNS - 1) phase = P_DONE;
              else begin turn_m++; phase = P_LOAD; load_cnt = 0; end
            end
          end else perf_m++;
        end
        default: phase = P_IDLE;
      endcase
    end
  end

  task automatic push_layer(input int c);
    ev_t e;
    for (int t = 0; t < TURNS; t++) begin
      for (int ch = 1; ch <= c; ch++) begin
        e.ch = ch; e.last = (ch == c); e.turn = t; e.rd = 1'b0;
        exp_q.push_back(e);
      end
      for (int w = 0; w < 4; w++) begin
        e.ch = 0; e.last = 1'b0; e.turn = t; e.rd = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input int c);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg = CHW'(c);
  endtask

  task automatic run_layer(input int c);
    int k;
    n_beats = 0; n_last = 0; n_reads = 0; n_done = 0;
    push_layer(c);
    pulse_start(c);
    for (k = 0; k < 6000; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (phase == P_IDLE) break;
      if (chaos) begin
        start = 1'($urandom_range(0, 1));
        cfg = CHW'($urandom_range(0, 127));
      end
    end
    if (k == 6000) miss("layer_timeout");
    chk("n_beats", n_beats, 4 * c);
    chk("n_last", n_last, 4);
    chk("n_reads", n_reads, 16);
    chk("n_done", n_done, 1);
    chk("sb_empty", exp_q.size(), 0);
`ifdef GATHER_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, perf_m);
`endif
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; cfg = '0;
    gaps = 0; rand_ack = 0; stray = 0; chaos = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_layer(3);

    pulse_start(0);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_busy", busy, 0);
    chk("t2_cfg_err", cfg_err, 1);
    run_layer(2);
    chk("t2_cfg_err_sticky", cfg_err, 1);

    run_layer(1);

    gaps = 1; rand_ack = 1;
    run_layer(5);
    run_layer(127);

    // reset while draining turn 2
    push_layer(4);
    pulse_start(4);
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (phase == P_DRAIN && turn_m == 2) break;
    end
    if (k == 3000) miss("reach_drain_t2");
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_turn_idx", turn_idx, 0);
    chk("t5_rd_req", rd_req, 0);
    chk("t5_cfg_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_layer(2);

    stray = 1; chaos = 1;
    for (int i = 0; i < 3; i++) run_layer(int'($urandom_range(1, 9)));
    chaos = 0; stray = 0; gaps = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
